// File: rtl/tbcm_matrix_arbiter_pkg.sv
// tbcm_matrix_arbiter_pkg: arbitration policy selector shared by matrix-arbiter users
package tbcm_matrix_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_INC_RR = 2'd0,
    ARB_DEC_RR = 2'd1,
    ARB_LRG    = 2'd2,
    ARB_MRG    = 2'd3
  } tbcm_matrix_arbiter_type;
endpackage

// File: rtl/tbcm_stream_arbiter_pkg.sv
// tbcm_stream_arbiter_pkg: FSM state and counter width for the packet stream arbiter
package tbcm_stream_arbiter_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tbcm_stream_arbiter_state;
  localparam int CNT_W = 8;
endpackage

// File: rtl/tbcm_matrix_arbiter.sv
// tbcm_matrix_arbiter: priority-matrix arbiter with incremental/decremental RR, LRG and MRG updates
module tbcm_matrix_arbiter
  import tbcm_matrix_arbiter_pkg::*;
#(
  parameter int REQUESTS    = 2,
  parameter int KEEP_RESULT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_reset_priority,
  input  tbcm_matrix_arbiter_type i_arbiter_type,
  input  logic [REQUESTS-1:0]     i_request,
  input  logic                    i_free,
  output logic [REQUESTS-1:0]     o_grant
);
  typedef logic [REQUESTS-1:0][REQUESTS-1:0] matrix_t;
  function automatic matrix_t init_matrix();
    matrix_t m;
    for (int i = 0; i < REQUESTS; i++)
      for (int j = 0; j < REQUESTS; j++)
        m[i][j] = i <= j;
    return m;
  endfunction
  // pri[i][j] set means i wins over j; the diagonal stays set so a row masks only rivals
  matrix_t pri, pri_nxt;
  logic [REQUESTS-1:0] win, held, above, below;
  logic hold, update;
  always_comb begin
    win = '0;
    above = '0;
    below = '0;
    pri_nxt = '0;
    for (int i = 0; i < REQUESTS; i++)
      win[i] = i_request[i] & ~|(i_request & ~pri[i]);
    for (int i = 0; i < REQUESTS; i++) begin
      above[i] = |(win & REQUESTS'((64'd1 << i) - 64'd1));
      below[i] = |(win >> (i + 1));
    end
    for (int i = 0; i < REQUESTS; i++)
      for (int j = 0; j < REQUESTS; j++)
        pri_nxt[i][j] = (i == j) ? 1'b1 :
          (i_arbiter_type == ARB_INC_RR) ? ((above[i] != above[j]) ? above[i] : (i < j)) :
          (i_arbiter_type == ARB_DEC_RR) ? ((below[i] != below[j]) ? below[i] : (i > j)) :
          win[i] ? (i_arbiter_type == ARB_MRG) :
          win[j] ? (i_arbiter_type == ARB_LRG) : pri[i][j];
  end
  assign hold    = (KEEP_RESULT != 0) && (held != '0);
  assign o_grant = hold ? held : win;
  assign update  = !hold && (win != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pri  <= init_matrix();
      held <= '0;
    end else begin
      pri  <= i_reset_priority ? init_matrix() : update ? pri_nxt : pri;
      held <= (KEEP_RESULT == 0 || i_free) ? '0 : o_grant;
    end
endmodule

// File: rtl/tbcm_stream_arbiter.sv
// tbcm_stream_arbiter: packet-aware N:1 stream merger that holds an owner for up to QUOTA packets
module tbcm_stream_arbiter
  import tbcm_matrix_arbiter_pkg::*;
  import tbcm_stream_arbiter_pkg::*;
#(
  parameter int REQUESTS = 2,
  parameter int WIDTH    = 32,
  parameter int QUOTA    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_reset_priority,
  input  tbcm_matrix_arbiter_type         i_arbiter_type,
  input  logic [REQUESTS-1:0]             i_valid,
  output logic [REQUESTS-1:0]             o_ready,
  input  logic [REQUESTS-1:0][WIDTH-1:0]  i_data,
  input  logic [REQUESTS-1:0]             i_last,
  output logic                            o_valid,
  output logic [WIDTH-1:0]                o_data,
  output logic                            o_last,
  input  logic                            i_ready,
  output logic [REQUESTS-1:0]             o_grant
);
  tbcm_stream_arbiter_state state;
  logic [REQUESTS-1:0] grant_q, arb_req, arb_grant;
  logic [CNT_W-1:0] pkt_cnt, pkt_cnt_nxt;
  logic mid, xfer, idle;
  assign idle    = state == ST_IDLE;
  assign arb_req = idle ? i_valid : '0;
  tbcm_matrix_arbiter #(
    .REQUESTS    (REQUESTS),
    .KEEP_RESULT (0)
  ) u_arb (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_reset_priority (i_reset_priority),
    .i_arbiter_type   (i_arbiter_type),
    .i_request        (arb_req),
    .i_free           (1'b0),
    .o_grant          (arb_grant)
  );
  // grant_q is all-zero whenever the FSM is idle, so it alone gates every output
  assign o_grant = grant_q;
  assign o_ready = grant_q & {REQUESTS{i_ready}};
  assign o_valid = |(grant_q & i_valid);
  assign o_last  = |(grant_q & i_last);
  always_comb begin
    o_data = '0;
    for (int r = 0; r < REQUESTS; r++)
      o_data = o_data | (i_data[r] & {WIDTH{grant_q[r]}});
  end
  assign xfer        = o_valid & i_ready;
  assign pkt_cnt_nxt = pkt_cnt + CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      pkt_cnt <= '0;
      mid     <= 1'b0;
    end else if (idle) begin
      if (i_valid != '0) begin
        state   <= ST_BUSY;
        grant_q <= arb_grant;
        pkt_cnt <= '0;
        mid     <= 1'b0;
      end
    end else if (xfer) begin
      mid <= !o_last;
      if (o_last) begin
        pkt_cnt <= pkt_cnt_nxt;
        if (pkt_cnt_nxt == CNT_W'(QUOTA)) begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      end
    end else if (!mid && !o_valid) begin
      state   <= ST_IDLE;
      grant_q <= '0;
    end
endmodule

// File: tb/tb_tbcm_stream_arbiter.sv
// tb_tbcm_stream_arbiter: vector table on a QUOTA=1 instance, directed corner sequences and
// randomized traffic on a QUOTA=3 instance compared against a priority-list reference model
module tb_tbcm_stream_arbiter;
  import tbcm_matrix_arbiter_pkg::*;
  localparam int N = 4, W = 16, Q = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic rp, rdy, ov, ol, rp1, rdy1, ov1, ol1;
  tbcm_matrix_arbiter_type at, at1;
  logic [N-1:0] v, l, g, ro, v1, l1, g1, ro1;
  logic [N-1:0][W-1:0] d, d1;
  logic [W-1:0] od, od1;
  int checks = 0, fails = 0;
  int owner, cnt, pri[$];
  bit mid;
  tbcm_stream_arbiter #(.REQUESTS(N), .WIDTH(W), .QUOTA(Q)) dut (
    .clk(clk), .rst_n(rst_n), .i_reset_priority(rp), .i_arbiter_type(at),
    .i_valid(v), .o_ready(ro), .i_data(d), .i_last(l),
    .o_valid(ov), .o_data(od), .o_last(ol), .i_ready(rdy), .o_grant(g));
  tbcm_stream_arbiter #(.REQUESTS(N), .WIDTH(W), .QUOTA(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_reset_priority(rp1), .i_arbiter_type(at1),
    .i_valid(v1), .o_ready(ro1), .i_data(d1), .i_last(l1),
    .o_valid(ov1), .o_data(od1), .o_last(ol1), .i_ready(rdy1), .o_grant(g1));
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // reference priority is an ordered list of stream indices, most preferred first
  function automatic void pri_reset();
    pri.delete();
    for (int i = 0; i < N; i++) pri.push_back(i);
  endfunction
  function automatic void pri_update(int gi, tbcm_matrix_arbiter_type t);
    int q[$];
    if (t == ARB_INC_RR) for (int k = 1; k <= N; k++) q.push_back((gi + k) % N);
    else if (t == ARB_DEC_RR) for (int k = 1; k <= N; k++) q.push_back((gi - k + N) % N);
    else begin
      q = pri.find(x) with (x != gi);
      if (t == ARB_LRG) q.push_back(gi);
      else q.push_front(gi);
    end
    pri = q;
  endfunction
  function automatic void model_reset();
    owner = -1;
    cnt = 0;
    mid = 0;
    pri_reset();
  endfunction
  function automatic void model_step();
    int p = -1;
    if (owner < 0) begin
      if (v != '0) begin
        foreach (pri[k]) if (p < 0 && v[pri[k]]) p = pri[k];
        owner = p;
        cnt = 0;
        mid = 0;
        if (!rp) pri_update(p, at);
      end
    end else if (v[owner] && rdy) begin
      if (l[owner]) begin
        mid = 0;
        cnt++;
        if (cnt == Q) owner = -1;
      end else mid = 1;
    end else if (!mid && !v[owner]) owner = -1;
    if (rp) pri_reset();
  endfunction
  function automatic void model_check();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    eg = owner < 0 ? '0 : N'(1) << owner;
    ed = '0;
    for (int i = 0; i < N; i++) if (eg[i]) ed = d[i];
    chk("grant", 64'(g), 64'(eg));
    chk("valid", 64'(ov), 64'(|(v & eg)));
    chk("last", 64'(ol), 64'(|(l & eg)));
    chk("ready", 64'(ro), 64'(eg & {N{rdy}}));
    if (owner >= 0) chk("data", 64'(od), 64'(ed));
  endfunction
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic step(input int e);
    sample();
    if (e >= 0) chk("dir_grant", 64'(g), 64'(e));
    tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {v, l, rdy, rp, v1, l1, rdy1, rp1} = '0;
    at = ARB_INC_RR;
    at1 = ARB_INC_RR;
    for (int i = 0; i < N; i++) begin
      d[i] = W'($urandom);
      d1[i] = W'(16'hA0 + i);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  typedef struct {
    logic         rdy;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
  } vec_t;
  vec_t tab[15];
  int beats;
  initial begin
    {v, l, rdy, rp, v1, l1, rdy1, rp1} = '0;
    at = ARB_INC_RR;
    at1 = ARB_INC_RR;
    d = '0;
    d1 = '0;
    #2;
    chk("rst_grant", 64'(g), 64'(0));
    chk("rst_valid", 64'(ov), 64'(0));
    chk("rst_ready", 64'(ro), 64'(0));
    chk("rst_grant1", 64'(g1), 64'(0));
    // QUOTA=1, all streams send single-beat packets: one idle cycle between grants
    tab = '{'{1'b1, 4'h0, 16'h00}, '{1'b1, 4'h1, 16'hA0}, '{1'b1, 4'h0, 16'h00},
            '{1'b1, 4'h2, 16'hA1}, '{1'b1, 4'h0, 16'h00}, '{1'b1, 4'h4, 16'hA2},
            '{1'b1, 4'h0, 16'h00}, '{1'b1, 4'h8, 16'hA3}, '{1'b1, 4'h0, 16'h00},
            '{1'b1, 4'h1, 16'hA0}, '{1'b0, 4'h0, 16'h00}, '{1'b0, 4'h2, 16'hA1},
            '{1'b0, 4'h2, 16'hA1}, '{1'b1, 4'h2, 16'hA1}, '{1'b1, 4'h0, 16'h00}};
    do_reset();
    v1 = '1;
    l1 = '1;
    for (int i = 0; i < 15; i++) begin
      rdy1 = tab[i].rdy;
      @(negedge clk);
      chk("tab_grant", 64'(g1), 64'(tab[i].eg));
      chk("tab_valid", 64'(ov1), 64'(tab[i].eg != '0));
      chk("tab_ready", 64'(ro1), 64'(tab[i].eg & {N{tab[i].rdy}}));
      if (tab[i].eg != '0) chk("tab_data", 64'(od1), 64'(tab[i].ed));
      @(posedge clk);
      #1;
    end
    // 5-beat packet on stream 2 with i_ready toggling; stream 0 must be held off
    do_reset();
    v = 4'b0100;
    rdy = 1'b1;
    step(0);
    v = 4'b0101;
    beats = 0;
    for (int c = 0; c < 20 && beats < 5; c++) begin
      rdy = (c % 2 == 0);
      l = (beats == 4) ? 4'b0100 : 4'b0000;
      d[2] = W'(16'h200 + beats);
      sample();
      chk("lock_grant", 64'(g), 64'(4'b0100));
      chk("s0_ready", 64'(ro[0]), 64'(0));
      if (rdy) beats++;
      tick();
    end
    v = 4'b0001;
    l = 4'b0000;
    step(4);
    step(0);
    step(1);
    // QUOTA=3: four back-to-back packets on stream 1
    do_reset();
    v = 4'b0010;
    l = 4'b0010;
    rdy = 1'b1;
    foreach (tab[i]) if (i < 6) step(i == 0 || i == 4 ? 0 : 2);
    v = 4'b0000;
    step(2);
    step(0);
    // stream 1 sends one packet then drops valid; stream 3 waits
    do_reset();
    v = 4'b1010;
    l = 4'b1010;
    rdy = 1'b1;
    step(0);
    step(2);
    v = 4'b1000;
    step(2);
    step(0);
    step(8);
    // asynchronous reset in the middle of a packet
    do_reset();
    v = 4'b0010;
    rdy = 1'b1;
    step(0);
    step(2);
    step(2);
    sample();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov), 64'(0));
    chk("arst_ready", 64'(ro), 64'(0));
    chk("arst_grant", 64'(g), 64'(0));
    chk("arst_last", 64'(ol), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    v = 4'b1001;
    l = 4'b1001;
    rst_n = 1'b1;
    step(0);
    step(1);
    // LRG with a priority reset pulsed while stream 0 owns the output
    do_reset();
    at = ARB_LRG;
    v = 4'b0011;
    l = 4'b0011;
    rdy = 1'b1;
    step(0);
    rp = 1'b1;
    step(1);
    rp = 1'b0;
    step(1);
    step(1);
    step(0);
    step(1);
    step(1);
    step(1);
    step(0);
    step(2);
    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = $urandom_range(0, 9) < 7;
        l[i] = $urandom_range(0, 9) < 3;
        d[i] = W'($urandom);
      end
      rdy = $urandom_range(0, 9) < 7;
      rp = $urandom_range(0, 19) == 0;
      at = tbcm_matrix_arbiter_type'(2'($urandom_range(0, 3)));
      step(-1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
